// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the sequential KGP ALU: opcode map, FSM encoding,
// and the predicate that tells which ops take the iterative datapath.
package kgp_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_PASS = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_DIV  = 4'd13;
    localparam logic [3:0] OP_RSV  = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/kgp_alu_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) datapath.
// One step per cycle while step is high; done pulses with the final step.
module kgp_alu_iter #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               step,
    output logic               done,
    output logic [2*WIDTH-1:0] result_next
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dvs;
    logic             div_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   hi_nx;
    logic [WIDTH-1:0] lo_nx;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   sum;

    // hi is the running remainder (DIV) or upper partial product (MUL);
    // lo shifts out dividend/multiplier bits and shifts in quotient/product bits.
    always_comb begin
        r_sh  = {hi[WIDTH-1:0], lo[WIDTH-1]};
        diff  = r_sh - {1'b0, dvs};
        sum   = lo[0] ? (hi + {1'b0, dvs}) : hi;
        hi_nx = hi;
        lo_nx = lo;
        if (div_q) begin
            if (r_sh >= {1'b0, dvs}) begin
                hi_nx = diff;
                lo_nx = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = r_sh;
                lo_nx = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx = {1'b0, sum[WIDTH:1]};
            lo_nx = {sum[0], lo[WIDTH-1:1]};
        end
    end

    assign result_next = {hi_nx[WIDTH-1:0], lo_nx};
    assign done        = step && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            dvs   <= '0;
            div_q <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            hi    <= '0;
            lo    <= a;
            dvs   <= b;
            div_q <= div_mode;
            cnt   <= '0;
        end else if (step) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/kgp_alu_seq.sv
// Handshaked KGP ALU: single-cycle logic/shift/add ops, iterative MUL/DIV.
// in_ready/in_valid and out_valid/out_ready transfer on any edge where both are high.
module kgp_alu_seq
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int OPW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [OPW-1:0]     op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_z,
    output logic               flag_c,
    output logic               flag_v,
    output logic               flag_dz,
    output state_t             fsm_state
);
    state_t          state;
    logic [OPW-1:0]  op_q;
    logic            b_zero_q;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH-1:0]   diff_w;
    logic [WIDTH-1:0]   lo_w;
    logic               shift_big;
    logic [2*WIDTH-1:0] sc_res;
    logic               sc_c;
    logic               sc_v;

    logic               iter_start;
    logic               iter_done;
    logic [2*WIDTH-1:0] iter_res;

    assign in_ready  = (state == ST_IDLE);
    assign fsm_state = state;

    always_comb begin
        sum_w     = {1'b0, a} + {1'b0, b};
        diff_w    = a - b;
        shift_big = (b >= WIDTH'(WIDTH));
        lo_w      = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (op)
            OP_ADD: begin
                sc_c = sum_w[WIDTH];
                sc_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                lo_w = diff_w;
                sc_c = (a < b);
                sc_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  lo_w = a & b;
            OP_OR:   lo_w = a | b;
            OP_XOR:  lo_w = a ^ b;
            OP_NOT:  lo_w = ~a;
            OP_SHL:  lo_w = shift_big ? '0 : (a << b);
            OP_SHR:  lo_w = shift_big ? '0 : (a >> b);
            OP_SRA:  lo_w = shift_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
            OP_SLT:  lo_w = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: lo_w = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_PASS: lo_w = a;
            default: lo_w = '0;
        endcase
        // ADD keeps its carry in bit WIDTH of the result.
        if (op == OP_ADD) sc_res = {{(WIDTH-1){1'b0}}, sum_w};
        else              sc_res = {{WIDTH{1'b0}}, lo_w};
    end

    assign iter_start = (state == ST_IDLE) && in_valid && is_multicycle(op);

    kgp_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (iter_start),
        .div_mode    (op == OP_DIV),
        .a           (a),
        .b           (b),
        .step        (state == ST_BUSY),
        .done        (iter_done),
        .result_next (iter_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            b_zero_q  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_dz   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        b_zero_q <= (b == '0);
                        if (is_multicycle(op)) begin
                            state <= ST_BUSY;
                        end else begin
                            result    <= sc_res;
                            flag_z    <= (sc_res == '0);
                            flag_c    <= sc_c;
                            flag_v    <= sc_v;
                            flag_dz   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (iter_done) begin
                        result    <= iter_res;
                        flag_z    <= (iter_res == '0);
                        flag_c    <= 1'b0;
                        flag_v    <= 1'b0;
                        flag_dz   <= (op_q == OP_DIV) && b_zero_q;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kgp_alu_seq.sv
// Self-checking bench for kgp_alu_seq (WIDTH=6): directed cases plus random ops
// compared against an arithmetic reference model, with latency and backpressure checks.
module tb_kgp_alu_seq;
    import kgp_alu_pkg::*;

    localparam int W  = 6;
    localparam int EW = 2 * W + 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [3:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           flag_z;
    logic           flag_c;
    logic           flag_v;
    logic           flag_dz;
    state_t         fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];

    kgp_alu_seq #(.WIDTH(W), .OPW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_dz   (flag_dz),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: returns {dz, v, c, z, result}
    function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic [3:0] mop);
        longint m, ua, ub, sa, sb, r, sr;
        logic z, c, v, dz;
        m  = longint'(1) << W;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        r = 0; c = 0; v = 0; dz = 0;
        case (mop)
            4'd0: begin
                r = ua + ub; c = (r >= m);
                sr = sa + sb; v = (sr >= m / 2) || (sr < -(m / 2));
            end
            4'd1: begin
                r = (ua - ub + m) % m; c = (ua < ub);
                sr = sa - sb; v = (sr >= m / 2) || (sr < -(m / 2));
            end
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ua ^ ub;
            4'd5:  r = (m - 1) - ua;
            4'd6:  r = (ub >= W) ? 0 : (ua << ub) % m;
            4'd7:  r = (ub >= W) ? 0 : (ua >> ub);
            4'd8:  r = (ub >= W) ? ((sa < 0) ? m - 1 : 0) : ((sa >>> ub) & (m - 1));
            4'd9:  r = (sa < sb) ? 1 : 0;
            4'd10: r = (ua < ub) ? 1 : 0;
            4'd11: r = ua;
            4'd12: r = ua * ub;
            4'd13: begin
                if (ub == 0) begin
                    r = ua * m + (m - 1); dz = 1;
                end else begin
                    r = (ua % ub) * m + (ua / ub);
                end
            end
            default: r = 0;
        endcase
        z = (r == 0);
        return {dz, v, c, z, r[2*W-1:0]};
    endfunction

    // driver: issue one op, check latency/result/flags, hold off drain for 'hold' cycles
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] top,
                          input int hold, output logic [2*W-1:0] got);
        logic [EW-1:0] e;
        int lat;
        int exp_lat;
        exp_q.push_back(model(ta, tb_, top));
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            check("in_ready_busy", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        exp_lat = (top == OP_MUL || top == OP_DIV) ? W + 1 : 1;
        check("latency", lat, exp_lat);
        e = exp_q.pop_front();
        check("result", result, e[2*W-1:0]);
        check("flag_z", flag_z, e[2*W]);
        check("flag_c", flag_c, e[2*W+1]);
        check("flag_v", flag_v, e[2*W+2]);
        check("flag_dz", flag_dz, e[2*W+3]);
        got = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); op = 4'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", result, e[2*W-1:0]);
            check("hold_flags", {flag_dz, flag_v, flag_c, flag_z}, e[2*W+3:2*W]);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [2*W-1:0] got;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 0);
        check("rst_flags", {flag_dz, flag_v, flag_c, flag_z}, 0);

        // directed cases
        run_op(6'd8, 6'd2, OP_ADD, 0, got);     check("add_8_2", got, 10);
        run_op(6'h20, 6'd1, OP_SUB, 0, got);    check("sub_20_1", got, 12'h1F);
        run_op(6'd63, 6'd63, OP_MUL, 0, got);   check("mul_63_63", got, 3969);
        run_op(6'd45, 6'd7, OP_DIV, 0, got);    check("div_45_7", got, 198);
        run_op(6'd13, 6'd0, OP_DIV, 0, got);    check("div_13_0", got, 895);
        run_op(6'h24, 6'd9, OP_SRA, 0, got);    check("sra_24_9", got, 12'h3F);
        run_op(6'd1, 6'd5, OP_SHL, 0, got);     check("shl_1_5", got, 12'h20);
        run_op(6'd7, 6'd6, OP_SHR, 0, got);     check("shr_big", got, 0);
        run_op(6'd9, 6'd3, 4'd15, 0, got);      check("rsv_15", got, 0);
        run_op(6'd5, 6'd5, OP_ADD, 3, got);     check("bp_add_5_5", got, 10);
        run_op(6'd63, 6'd1, OP_ADD, 0, got);    check("add_carry", got, 64);

        // reset on the third BUSY cycle of a MUL
        while (!in_ready) @(negedge clk);
        a = 6'd63; b = 6'd63; op = OP_MUL; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_flags", {flag_dz, flag_v, flag_c, flag_z}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("postrst_in_ready", in_ready, 1);
        repeat (W + 2) @(negedge clk);
        check("postrst_no_stale", out_valid, 0);
        run_op(6'd1, 6'd1, OP_ADD, 0, got);     check("postrst_add", got, 2);

        // random ops with random backpressure
        for (int i = 0; i < 200; i++) begin
            logic [3:0] rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rop = 4'($urandom_range(0, 15));
            ra  = W'($urandom);
            rb  = (i % 4 == 0) ? W'($urandom_range(0, 2 * W)) : W'($urandom);
            if (i % 25 == 0) rb = '0;
            run_op(ra, rb, rop, $urandom_range(0, 3), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
